// File: rtl/r_arb_pkg.sv
// Shared widths, state encodings and helpers for the packet-level
// read-response arbiter.
package r_arb_pkg;

  localparam int ARB_NUM_SRC = 4;
  localparam int ARB_DATA_W  = 128;
  localparam int ARB_KEEP_W  = ARB_DATA_W / 8;
  localparam int CONN_ID_W   = 4;
  localparam int BYTE_NUM_W  = 13;
  localparam int SRC_IDX_W   = 2;

  // Two-bit encoding so that 2'b00 and 2'b11 are detectable as illegal.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_BURST = 2'b10
  } arb_state_e;

  function automatic logic [SRC_IDX_W-1:0] next_src(input logic [SRC_IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority winner select: first asserted request starting at ptr,
// wrapping modulo the source count.
module rr_priority_pick
  import r_arb_pkg::*;
(
  input  logic [ARB_NUM_SRC-1:0] req,
  input  logic [SRC_IDX_W-1:0]   ptr,
  output logic [SRC_IDX_W-1:0]   gnt_idx,
  output logic                   any
);

  logic [SRC_IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = ARB_NUM_SRC - 1; i >= 0; i--) begin
      cand = ptr + SRC_IDX_W'(i);
      if (req[cand]) begin
        gnt_idx = cand;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/r_channel_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC read-response streams
// onto one registered output channel.
//
// state    | meaning
// ST_IDLE  | no grant held, no in_ready; pick a winner if any source is valid
// ST_BURST | grant_q owns the output until its last beat is accepted
module r_channel_arbiter
  import r_arb_pkg::*;
#(
  parameter  int NUM_SRC = ARB_NUM_SRC,
  parameter  int DATA_W  = ARB_DATA_W,
  localparam int KEEP_W  = DATA_W / 8
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic [NUM_SRC*DATA_W-1:0]       in_data,
  input  logic [NUM_SRC*CONN_ID_W-1:0]    in_conn_id,
  input  logic [NUM_SRC*BYTE_NUM_W-1:0]   in_byte_num,
  input  logic [NUM_SRC*KEEP_W-1:0]       in_keep,
  input  logic [NUM_SRC-1:0]              in_last,
  input  logic [NUM_SRC-1:0]              in_valid,
  output logic [NUM_SRC-1:0]              in_ready,

  output logic [DATA_W-1:0]               out_data,
  output logic [CONN_ID_W-1:0]            out_conn_id,
  output logic [BYTE_NUM_W-1:0]           out_byte_num,
  output logic [KEEP_W-1:0]               out_keep,
  output logic                            out_last,
  output logic [SRC_IDX_W-1:0]            out_src,
  output logic                            out_valid,
  input  logic                            out_ready,

  output logic [31:0]                     pkt_cnt
);

  arb_state_e             state_q;
  logic [SRC_IDX_W-1:0]   grant_q;
  logic [SRC_IDX_W-1:0]   rr_ptr_q;

  logic [DATA_W-1:0]      out_data_q;
  logic [CONN_ID_W-1:0]   out_conn_id_q;
  logic [BYTE_NUM_W-1:0]  out_byte_num_q;
  logic [KEEP_W-1:0]      out_keep_q;
  logic                   out_last_q;
  logic [SRC_IDX_W-1:0]   out_src_q;
  logic                   out_valid_q;
  logic [31:0]            pkt_cnt_q;

  logic                   out_valid_d;
  logic [31:0]            pkt_cnt_d;

  logic [SRC_IDX_W-1:0]   pick_idx;
  logic                   pick_any;

  logic                   out_free;
  logic                   transfer;

  logic [DATA_W-1:0]      sel_data;
  logic [CONN_ID_W-1:0]   sel_conn_id;
  logic [BYTE_NUM_W-1:0]  sel_byte_num;
  logic [KEEP_W-1:0]      sel_keep;
  logic                   sel_last;
  logic                   sel_valid;

  rr_priority_pick u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Beat fields of the current grantee.
  always_comb begin
    sel_data     = in_data[int'(grant_q)*DATA_W +: DATA_W];
    sel_conn_id  = in_conn_id[int'(grant_q)*CONN_ID_W +: CONN_ID_W];
    sel_byte_num = in_byte_num[int'(grant_q)*BYTE_NUM_W +: BYTE_NUM_W];
    sel_keep     = in_keep[int'(grant_q)*KEEP_W +: KEEP_W];
    sel_last     = in_last[grant_q];
    sel_valid    = in_valid[grant_q];
  end

  // in_ready depends only on registered state and the downstream ready,
  // never on any in_valid.
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    in_ready = '0;
    if (state_q == ST_BURST) begin
      in_ready[grant_q] = out_free;
    end
  end

  assign transfer    = (state_q == ST_BURST) & sel_valid & out_free;
  assign out_valid_d = (out_valid_q & ~out_ready) | transfer;
  assign pkt_cnt_d   = (out_valid_q & out_ready & out_last_q) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      out_data_q     <= '0;
      out_conn_id_q  <= '0;
      out_byte_num_q <= '0;
      out_keep_q     <= '0;
      out_last_q     <= 1'b0;
      out_src_q      <= '0;
      out_valid_q    <= 1'b0;
      pkt_cnt_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      if (transfer) begin
        out_data_q     <= sel_data;
        out_conn_id_q  <= sel_conn_id;
        out_byte_num_q <= sel_byte_num;
        out_keep_q     <= sel_keep;
        out_last_q     <= sel_last;
        out_src_q      <= grant_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (transfer && sel_last) begin
            rr_ptr_q <= next_src(grant_q);
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          // Corrupted state: recover exactly as from reset.
          state_q        <= ST_IDLE;
          grant_q        <= '0;
          rr_ptr_q       <= '0;
          out_data_q     <= '0;
          out_conn_id_q  <= '0;
          out_byte_num_q <= '0;
          out_keep_q     <= '0;
          out_last_q     <= 1'b0;
          out_src_q      <= '0;
          out_valid_q    <= 1'b0;
          pkt_cnt_q      <= '0;
        end
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_conn_id  = out_conn_id_q;
  assign out_byte_num = out_byte_num_q;
  assign out_keep     = out_keep_q;
  assign out_last     = out_last_q;
  assign out_src      = out_src_q;
  assign out_valid    = out_valid_q;
  assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_r_channel_arbiter.sv
// Directed bench for r_channel_arbiter: packet-level reference model with a
// per-cycle compare, plus hand-computed order/latency/count expectations.
module tb_r_channel_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NS*DW-1:0]  in_data;
  logic [NS*4-1:0]   in_conn_id;
  logic [NS*13-1:0]  in_byte_num;
  logic [NS*KW-1:0]  in_keep;
  logic [NS-1:0]     in_last;
  logic [NS-1:0]     in_valid;
  logic [NS-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic [3:0]        out_conn_id;
  logic [12:0]       out_byte_num;
  logic [KW-1:0]     out_keep;
  logic              out_last;
  logic [1:0]        out_src;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       pkt_cnt;

  r_channel_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_conn_id   (in_conn_id),
    .in_byte_num  (in_byte_num),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_conn_id  (out_conn_id),
    .out_byte_num (out_byte_num),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .out_src      (out_src),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pkt_cnt      (pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    conn;
    logic [12:0]   bn;
    logic [KW-1:0] keep;
    logic          last;
    int            src;
  } beat_t;

  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    out_order[$];
  int    start_cyc[$];
  int    last_cyc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tot_acc  = 0;
  int tag      = 0;

  int          m_owner;
  bit          m_owner_v;
  int          m_ptr;
  int          m_cnt;
  logic [NS-1:0] xfer;
  int          stall_cnt[NS];
  int          stall_at[NS];
  int          stall_len[NS];
  int          sent[NS];
  bit          stall_done[NS];
  bit          prev_hold;
  logic [DW-1:0] snap_data;
  logic [35:0] snap_f;
  bit          out_in_pkt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NS-1:0] v, input int p);
    for (int i = 0; i < NS; i++) begin
      if (v[(p + i) % NS]) return (p + i) % NS;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = m_owner_v || (exp_q.size() != 0);
    for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) b = 1'b1;
    return b;
  endfunction

  function automatic int order_code();
    int c;
    c = 0;
    foreach (out_order[i]) c = c * 10 + out_order[i] + 1;
    return c;
  endfunction

  task automatic add_pkt(input int s, input int n);
    beat_t b;
    tag++;
    for (int i = 0; i < n; i++) begin
      b.data = {32'(tag * 1000 + i), 32'(s), 32'hDEAD_0000 | 32'(i), 32'(s * 17 + tag)};
      b.conn = 4'(tag + s);
      b.bn   = 13'(tag * 64 + i * 8 + s);
      b.last = (i == n - 1);
      b.keep = b.last ? KW'(16'h00FF >> s) : {KW{1'b1}};
      b.src  = s;
      src_q[s].push_back(b);
    end
  endtask

  task automatic apply();
    beat_t b;
    for (int s = 0; s < NS; s++) begin
      if (src_q[s].size() > 0 && stall_cnt[s] == 0) begin
        b = src_q[s][0];
        in_valid[s]              = 1'b1;
        in_data[s*DW +: DW]      = b.data;
        in_conn_id[s*4 +: 4]     = b.conn;
        in_byte_num[s*13 +: 13]  = b.bn;
        in_keep[s*KW +: KW]      = b.keep;
        in_last[s]               = b.last;
      end else begin
        in_valid[s]              = 1'b0;
        in_data[s*DW +: DW]      = '0;
        in_conn_id[s*4 +: 4]     = '0;
        in_byte_num[s*13 +: 13]  = '0;
        in_keep[s*KW +: KW]      = '0;
        in_last[s]               = 1'b0;
      end
    end
  endtask

  // Compare DUT against the packet-level model, then advance the model to
  // the upcoming clock edge.
  task automatic model_eval();
    beat_t e;
    int    p;
    logic  exp_rdy;
    if (reset) begin
      m_owner_v  = 1'b0;
      m_ptr      = 0;
      m_cnt      = 0;
      exp_q.delete();
      prev_hold  = 1'b0;
      out_in_pkt = 1'b0;
      xfer       = '0;
      for (int s = 0; s < NS; s++) begin
        src_q[s].delete();
        stall_cnt[s] = 0;
      end
      return;
    end
    for (int s = 0; s < NS; s++) begin
      exp_rdy = (m_owner_v && m_owner == s) ? (!out_valid || out_ready) : 1'b0;
      chk($sformatf("in_ready[%0d]", s), in_ready[s], exp_rdy);
    end
    chk("pkt_cnt", pkt_cnt, m_cnt);
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, snap_data);
      chk("hold_fields", {out_src, out_conn_id, out_byte_num, out_keep, out_last}, snap_f);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_fields", {out_src, out_conn_id, out_byte_num, out_keep, out_last},
            {2'(e.src), e.conn, e.bn, e.keep, e.last});
      end
      if (!out_in_pkt) begin
        out_order.push_back(int'(out_src));
        start_cyc.push_back(cyc);
      end
      out_in_pkt = !out_last;
      if (out_last) begin
        last_cyc.push_back(cyc);
        m_cnt++;
      end
      tot_acc++;
    end
    prev_hold = out_valid && !out_ready;
    snap_data = out_data;
    snap_f    = {out_src, out_conn_id, out_byte_num, out_keep, out_last};
    xfer      = in_valid & in_ready;

    if (m_owner_v) begin
      if (src_q[m_owner].size() > 0 && in_valid[m_owner] && (!out_valid || out_ready)
          && src_q[m_owner][0].last) begin
        m_owner_v = 1'b0;
        m_ptr     = (m_owner + 1) % NS;
      end
    end else begin
      p = rr_pick(in_valid, m_ptr);
      if (p >= 0) begin
        m_owner   = p;
        m_owner_v = 1'b1;
        for (int i = 0; i < src_q[p].size(); i++) begin
          exp_q.push_back(src_q[p][i]);
          if (src_q[p][i].last) break;
        end
      end
    end
  endtask

  task automatic update();
    beat_t e;
    for (int s = 0; s < NS; s++) begin
      if (xfer[s] && src_q[s].size() > 0) begin
        e = src_q[s].pop_front();
        sent[s]++;
      end
      if (stall_cnt[s] > 0) stall_cnt[s]--;
      if (!stall_done[s] && stall_at[s] > 0 && sent[s] == stall_at[s]) begin
        stall_cnt[s]  = stall_len[s];
        stall_done[s] = 1'b1;
      end
    end
    xfer = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
    update();
    apply();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      cycle();
      k++;
    end
    chk("idle_timeout", busy(), 1'b0);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k;
    k = 0;
    while (tot_acc < n && k < budget) begin
      cycle();
      k++;
    end
    chk("accept_timeout", tot_acc >= n, 1'b1);
  endtask

  task automatic clear_logs();
    out_order.delete();
    start_cyc.delete();
    last_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int a0;
    for (int s = 0; s < NS; s++) begin
      stall_cnt[s] = 0; stall_at[s] = 0; stall_len[s] = 0; sent[s] = 0; stall_done[s] = 1'b0;
    end
    m_owner = 0; m_owner_v = 1'b0; m_ptr = 0; m_cnt = 0; xfer = '0;
    prev_hold = 1'b0; out_in_pkt = 1'b0;
    reset     = 1'b1;
    out_ready = 1'b1;
    apply();
    repeat (3) cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_fields", {out_src, out_conn_id, out_byte_num, out_keep, out_last}, 36'd0);
    reset = 1'b0;

    // Single source 2, three beats, free output path.
    clear_logs();
    t0 = cyc;
    add_pkt(2, 3);
    apply();
    wait_idle(50);
    chk("t1_order", order_code(), 3);
    chk("t1_first_beat_cycle", start_cyc.size() > 0 ? start_cyc[0] : -1, t0 + 2);
    chk("t1_last_beat_cycle", last_cyc.size() > 0 ? last_cyc[0] : -1, t0 + 4);
    chk("t1_pkt_cnt", pkt_cnt, 32'd1);

    // Pointer now 3: sources 0 and 3 requesting -> 3 first, then 0.
    clear_logs();
    add_pkt(0, 2);
    add_pkt(3, 2);
    apply();
    wait_idle(60);
    chk("wrap_order", order_code(), 41);
    chk("wrap_pkt_cnt", pkt_cnt, 32'd3);

    // Reset while beat 2 of 4 sits on the output.
    clear_logs();
    a0 = tot_acc;
    add_pkt(2, 4);
    apply();
    wait_acc(a0 + 1, 50);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    apply();
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_mid_in_ready", in_ready, 4'b0000);
    chk("rst_mid_beats_out", tot_acc - a0, 1);

    // Contention from pointer 0: order 0,1,2,3 with one idle cycle between.
    clear_logs();
    for (int s = 0; s < NS; s++) add_pkt(s, 2);
    apply();
    wait_idle(100);
    chk("cont_order", order_code(), 1234);
    chk("cont_pkt_cnt", pkt_cnt, 32'd4);
    for (int k = 1; k < start_cyc.size() && k < last_cyc.size(); k++) begin
      chk($sformatf("cont_gap_%0d", k), start_cyc[k] - last_cyc[k-1], 2);
    end

    // Backpressure: out_ready low for five cycles mid-packet.
    clear_logs();
    a0 = tot_acc;
    add_pkt(0, 4);
    apply();
    wait_acc(a0 + 2, 50);
    out_ready = 1'b0;
    repeat (5) cycle();
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_in_ready", in_ready, 4'b0000);
    out_ready = 1'b1;
    wait_idle(60);
    chk("bp_order", order_code(), 1);
    chk("bp_beats", tot_acc - a0, 4);
    chk("bp_pkt_cnt", pkt_cnt, 32'd5);

    // Grantee stall: src1 drops valid for three cycles after beat 2 while
    // src0 keeps requesting; src0 must wait for src1's last beat.
    clear_logs();
    sent[1] = 0; stall_at[1] = 2; stall_len[1] = 3; stall_done[1] = 1'b0;
    add_pkt(1, 4);
    add_pkt(0, 2);
    apply();
    wait_idle(100);
    chk("stall_order", order_code(), 21);
    chk("stall_span", (start_cyc.size() > 0 && last_cyc.size() > 0) ? last_cyc[0] - start_cyc[0] : -1, 6);
    chk("stall_pkt_cnt", pkt_cnt, 32'd7);

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/r_channel_arbiter.md
R_CHANNEL_ARBITER -- requirements
Module: r_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of read-response sources (fixed at 4 in this release).
REQ-002 SHALL have parameter DATA_W, default 128, beat width; KEEP_W = DATA_W/8.
REQ-003 SHALL have port clk, input, 1, clock; reset reset, synchronous, active-high.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_data[s], in_conn_id[s] (4), in_byte_num[s] (13), in_keep[s] (16), in_last[s], in_valid[s], all inputs, flattened per source s.
REQ-006 SHALL have port in_ready, output, NUM_SRC, per-source ready.
REQ-007 SHALL have outputs out_data (128), out_conn_id (4), out_byte_num (13), out_keep (16), out_last, out_src (2), out_valid, plus input out_ready.
REQ-008 SHALL have output pkt_cnt, 32, count of packets completed at output.

Function
REQ-009 SHALL arbitrate at packet granularity: once granted, a source owns the output until its last beat is accepted.
REQ-010 SHALL implement FSM IDLE/BURST; IDLE: no in_ready asserted; if any in_valid, pick winner, store grant_idx, go BURST next cycle.
REQ-011 SHALL pick the first valid source in order rr_ptr, rr_ptr+1, ... modulo 4.
REQ-012 SHALL in BURST drive in_ready[grant_idx] = ~out_valid | out_ready, all other in_ready 0.
REQ-013 SHALL derive in_ready only from registered state (no combinational in_valid -> in_ready path).
REQ-014 SHALL on transfer (in_valid & in_ready of grantee) register all beat fields into out_*, with out_src = grant_idx.
REQ-015 SHALL compute next out_valid = (out_valid & ~out_ready) | transfer; out_* fields hold while out_valid & ~out_ready.
REQ-016 SHALL on transfer with in_last return to IDLE and set rr_ptr = grant_idx+1 modulo 4 (3 wraps to 0).
REQ-017 SHALL hold grant when grantee deasserts in_valid mid-packet; no timeout.
REQ-018 SHALL have latency: first beat visible on out_valid 2 cycles after in_valid rises in IDLE with out path free; then 1 beat/cycle.
REQ-019 SHALL increment pkt_cnt on out_valid & out_ready & out_last, wrapping 0xFFFFFFFF -> 0.
REQ-020 SHALL on last-beat transfer with other requests pending spend one IDLE cycle, then grant by updated rr_ptr.
REQ-021 SHALL pass in_conn_id, in_byte_num, in_keep unmodified (no arithmetic on them).
REQ-022 SHALL treat illegal state encoding as reset: outputs clear, go IDLE.

Reset
REQ-023 SHALL on reset clear out_valid, out_last, out_data, out_conn_id, out_byte_num, out_keep, out_src, in_ready, pkt_cnt to 0, rr_ptr to 0, state to IDLE.
REQ-024 SHALL on reset mid-packet discard the partial packet with no completion beat; downstream detects truncation.

Structure
REQ-025 SHALL put NUM_SRC, DATA_W, KEEP_W, conn-id width 4, byte-num width 13, state encodings in shared package r_arb_pkg.
REQ-026 SHALL implement winner selection as combinational sub-module rr_priority_pick (req[3:0], ptr[1:0] -> gnt_idx, any).

Verification
REQ-027 SHALL cover single source: src2 sends 3-beat packet (last on beat 3), out_ready=1 -> out_src=2, beats at cycles T+2..T+4, pkt_cnt=1, rr_ptr=3.
REQ-028 SHALL cover contention: all 4 valid with 2-beat packets, rr_ptr=0 -> output order 0,1,2,3, one IDLE gap between packets, pkt_cnt=4.
REQ-029 SHALL cover backpressure: out_ready=0 for 5 cycles mid-packet -> out_* stable, in_ready[grant]=0, no beat lost or duplicated.
REQ-030 SHALL cover pointer wrap: rr_ptr=3, sources 0 and 3 valid -> src3 first, then src0.
REQ-031 SHALL cover reset mid-packet: assert reset on beat 2 of 4 -> next cycle out_valid=0, pkt_cnt=0, state IDLE, rr_ptr=0.
REQ-032 SHALL cover grantee stall: src1 drops in_valid 3 cycles mid-packet while src0 valid -> src0 never granted until src1 last accepted.
